// File: rtl/multi_button_processor_pkg.sv
// Shared types for the multi-button front end.
// Channel state encoding and event indices.
package multi_button_processor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_LONG     = 3'd3,
        ST_REL_DB   = 3'd4
    } btn_state_e;

    localparam int EV_SHORT  = 0;
    localparam int EV_LONG   = 1;
    localparam int EV_REPEAT = 2;
    localparam int NUM_EV    = 3;

    function automatic logic is_held(btn_state_e s);
        return s inside {ST_PRESSED, ST_LONG, ST_REL_DB};
    endfunction

endpackage

// File: rtl/multi_button_processor_channel.sv
// One button: synchroniser, debounce/classify FSM and
// three pulse stretchers (short, long, repeat).
module multi_button_processor_channel
    import multi_button_processor_pkg::*;
#(
    parameter int DEBOUNCE_TIME   = 20000,
    parameter int LONG_PRESS_TIME = 2000000,
    parameter int REPEAT_TIME     = 250000,
    parameter int PULSE_WIDTH     = 1000,
    parameter int CNT_W           = 21
) (
    input  logic clk_1mhz,
    input  logic rst_n,
    input  logic button_i,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DB_C = cnt_t'(DEBOUNCE_TIME);
    localparam cnt_t LP_C = cnt_t'(LONG_PRESS_TIME);
    localparam cnt_t RP_C = cnt_t'(REPEAT_TIME);
    localparam cnt_t PW_C = cnt_t'(PULSE_WIDTH);

    logic [1:0]  sync_q;
    logic        smp;
    btn_state_e  state_q, state_d;
    cnt_t        db_q, db_d;
    cnt_t        hold_q, hold_d;
    cnt_t        rep_q, rep_d;
    logic        ld_q, ld_d;
    logic        held_q;
    logic        go_rel, do_hold, do_rep, fin;
    logic [NUM_EV-1:0] ev_q, ev_d;
    logic [NUM_EV-1:0] pout_q, pout_d;
    logic [NUM_EV-1:0][CNT_W-1:0] pcnt_q, pcnt_d;

    assign smp = sync_q[1];

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], button_i};
    end

    // State, counters, long_done flag and event strobes.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            db_q    <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            ld_q    <= 1'b0;
            ev_q    <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            ld_q    <= ld_d;
            ev_q    <= ev_d;
            held_q  <= is_held(state_d);
        end
    end

    // Next state: debounce both edges, freeze timing during release bounce.
    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        ld_d    = ld_q;
        ev_d    = '0;
        go_rel  = 1'b0;
        do_hold = 1'b0;
        do_rep  = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                db_d   = '0;
                hold_d = '0;
                rep_d  = '0;
                if (smp) begin
                    if (DB_C == cnt_t'(1)) begin
                        state_d = ST_PRESSED;
                    end else begin
                        state_d = ST_PRESS_DB;
                        db_d    = cnt_t'(1);
                    end
                end
            end
            ST_PRESS_DB: begin
                if (!smp) begin
                    state_d = ST_IDLE;
                    db_d    = '0;
                end else if (db_q + 1'b1 == DB_C) begin
                    state_d = ST_PRESSED;
                    db_d    = '0;
                    hold_d  = '0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (smp) do_hold = 1'b1;
                else     go_rel  = 1'b1;
            end
            ST_LONG: begin
                if (smp) do_rep = 1'b1;
                else     go_rel = 1'b1;
            end
            ST_REL_DB: begin
                if (smp) begin
                    state_d = ld_q ? ST_LONG : ST_PRESSED;
                    db_d    = '0;
                    do_hold = !ld_q;
                    do_rep  = ld_q;
                end else if (db_q + 1'b1 == DB_C) begin
                    fin = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (go_rel) begin
            if (DB_C == cnt_t'(1)) begin
                fin = 1'b1;
            end else begin
                state_d = ST_REL_DB;
                db_d    = cnt_t'(1);
            end
        end
        if (fin) begin
            state_d        = ST_IDLE;
            ev_d[EV_SHORT] = !ld_q;
            ld_d           = 1'b0;
            db_d           = '0;
            hold_d         = '0;
            rep_d          = '0;
        end
        if (do_hold) begin
            hold_d = hold_q + 1'b1;
            if (hold_d == LP_C) begin
                state_d       = ST_LONG;
                ev_d[EV_LONG] = 1'b1;
                rep_d         = '0;
                ld_d          = 1'b1;
            end
        end
        if (do_rep && RP_C != '0) begin
            if (rep_q + 1'b1 == RP_C) begin
                rep_d           = '0;
                ev_d[EV_REPEAT] = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    // Pulse stretcher registers, one per event type.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            pout_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            pout_q <= pout_d;
        end
    end

    // An event reloads the full width; output stays high PULSE_WIDTH cycles.
    always_comb begin
        pcnt_d = pcnt_q;
        pout_d = '0;
        for (int e = 0; e < NUM_EV; e++) begin
            if (ev_q[e])                pcnt_d[e] = PW_C;
            else if (pcnt_q[e] != '0)   pcnt_d[e] = pcnt_q[e] - 1'b1;
            pout_d[e] = ev_q[e] | (pcnt_q[e] > cnt_t'(1));
        end
    end

    assign short_o  = pout_q[EV_SHORT];
    assign long_o   = pout_q[EV_LONG];
    assign repeat_o = pout_q[EV_REPEAT];
    assign held_o   = held_q;

endmodule

// File: rtl/multi_button_processor.sv
// N-channel pushbutton front end: independent
// debounced short/long/repeat classifiers per button.
module multi_button_processor
    import multi_button_processor_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_TIME   = 20000,
    parameter int LONG_PRESS_TIME = 2000000,
    parameter int REPEAT_TIME     = 250000,
    parameter int PULSE_WIDTH     = 1000,
    parameter int CNT_W           = 21
) (
    input  logic                   clk_1mhz,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] buttons_i,
    output logic [NUM_BUTTONS-1:0] short_o,
    output logic [NUM_BUTTONS-1:0] long_o,
    output logic [NUM_BUTTONS-1:0] repeat_o,
    output logic [NUM_BUTTONS-1:0] held_o
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        multi_button_processor_channel #(
            .DEBOUNCE_TIME  (DEBOUNCE_TIME),
            .LONG_PRESS_TIME(LONG_PRESS_TIME),
            .REPEAT_TIME    (REPEAT_TIME),
            .PULSE_WIDTH    (PULSE_WIDTH),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk_1mhz(clk_1mhz),
            .rst_n   (rst_n),
            .button_i(buttons_i[i]),
            .short_o (short_o[i]),
            .long_o  (long_o[i]),
            .repeat_o(repeat_o[i]),
            .held_o  (held_o[i])
        );
    end

endmodule

// File: tb/tb_multi_button_processor.sv
// Scoreboard bench: two DUTs (repeat on / repeat off) share stimulus;
// a run-length reference model predicts every pulse and held level.
module tb_multi_button_processor;

    localparam int N    = 2;
    localparam int DB   = 4;
    localparam int LP   = 20;
    localparam int RP   = 8;
    localparam int PW   = 3;
    localparam int CW   = 8;
    localparam int MAXL = 512;

    logic         clk_1mhz  = 1'b0;
    logic         rst_n     = 1'b0;
    logic [N-1:0] buttons_i = '0;
    logic [N-1:0] so [2];
    logic [N-1:0] lo [2];
    logic [N-1:0] ro [2];
    logic [N-1:0] ho [2];

    int edge_n = 0;
    int ntests = 0;
    int nfail  = 0;
    int exp_q [12][$];
    bit pat [2][$];
    bit hexp [2][MAXL];
    int hbase = 0;
    int hlen  = 0;
    bit prev [12];
    int rise_at [12];
    int first_rise [12];

    multi_button_processor #(
        .NUM_BUTTONS(N), .DEBOUNCE_TIME(DB), .LONG_PRESS_TIME(LP),
        .REPEAT_TIME(RP), .PULSE_WIDTH(PW), .CNT_W(CW)
    ) dut (
        .clk_1mhz(clk_1mhz), .rst_n(rst_n), .buttons_i(buttons_i),
        .short_o(so[0]), .long_o(lo[0]), .repeat_o(ro[0]), .held_o(ho[0])
    );

    multi_button_processor #(
        .NUM_BUTTONS(N), .DEBOUNCE_TIME(DB), .LONG_PRESS_TIME(LP),
        .REPEAT_TIME(0), .PULSE_WIDTH(PW), .CNT_W(CW)
    ) dut_norep (
        .clk_1mhz(clk_1mhz), .rst_n(rst_n), .buttons_i(buttons_i),
        .short_o(so[1]), .long_o(lo[1]), .repeat_o(ro[1]), .held_o(ho[1])
    );

    always #5 clk_1mhz = ~clk_1mhz;
    always @(posedge clk_1mhz) edge_n <= edge_n + 1;

    function automatic bit out_bit(int d, int ch, int t);
        case (t)
            0:       return so[d][ch];
            1:       return lo[d][ch];
            default: return ro[d][ch];
        endcase
    endfunction

    function automatic string tn(int t);
        case (t)
            0:       return "short";
            1:       return "long";
            default: return "repeat";
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Reference: counts of samples, not states. Event decided on sample j
    // shows on the outputs at edge base+j+4 (2 sync + 1 decide + 1 pulse).
    task automatic model(input int d, input int base);
        int rtime;
        rtime = (d == 0) ? RP : 0;
        for (int ch = 0; ch < N; ch++) begin
            int hr, lr, hold, rep;
            bit act, ld;
            hr = 0; lr = 0; hold = 0; rep = 0; act = 0; ld = 0;
            for (int j = 0; j < pat[ch].size(); j++) begin
                if (!act) begin
                    hr = pat[ch][j] ? hr + 1 : 0;
                    if (hr == DB) begin
                        act = 1; hold = 0; ld = 0; lr = 0; hr = 0;
                    end
                end else if (pat[ch][j]) begin
                    lr = 0;
                    if (!ld) begin
                        hold++;
                        if (hold == LP) begin
                            ld = 1; rep = 0;
                            exp_q[d*6+ch*3+1].push_back(base + j + 4);
                        end
                    end else begin
                        rep++;
                        if (rtime > 0 && rep % rtime == 0)
                            exp_q[d*6+ch*3+2].push_back(base + j + 4);
                    end
                end else begin
                    lr++;
                    if (lr == DB) begin
                        if (!ld) exp_q[d*6+ch*3+0].push_back(base + j + 4);
                        act = 0; hr = 0;
                    end
                end
                if (d == 0) hexp[ch][j] = act;
            end
        end
    endtask

    task automatic seg(input int ch, input bit v, input int len);
        for (int i = 0; i < len; i++) pat[ch].push_back(v);
    endtask

    task automatic clear_pat();
        pat[0].delete();
        pat[1].delete();
    endtask

    task automatic check_left();
        for (int i = 0; i < 12; i++) begin
            ntests++;
            if (exp_q[i].size() != 0) begin
                nfail++;
                $display("FAIL missing %s dut%0d ch%0d: got 0 pulses, required %0d more",
                         tn(i % 3), i / 6, (i / 3) % 2, exp_q[i].size());
            end
            exp_q[i].delete();
        end
    endtask

    task automatic run_scen(input bit rel_rst, input bit pad, output int base);
        int n, m;
        if (pad) begin
            m = (pat[0].size() > pat[1].size()) ? pat[0].size() : pat[1].size();
            m = m + DB + 12;
            while (pat[0].size() < m) pat[0].push_back(1'b0);
            while (pat[1].size() < m) pat[1].push_back(1'b0);
        end
        n = pat[0].size();
        @(negedge clk_1mhz);
        if (rel_rst) rst_n = 1'b1;
        base = edge_n;
        for (int i = 0; i < 12; i++) first_rise[i] = -1;
        model(0, base);
        model(1, base);
        hbase = base + 3;
        hlen  = n;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk_1mhz);
            buttons_i = {pat[1][k], pat[0][k]};
        end
        if (pad) begin
            repeat (8) @(negedge clk_1mhz);
            hlen = 0;
            check_left();
        end
    endtask

    // Monitor: pops the scoreboard on every rising output, checks widths
    // on every falling one and the held level each cycle.
    initial begin
        forever begin
            @(negedge clk_1mhz);
            if (!rst_n) begin
                for (int i = 0; i < 12; i++) prev[i] = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++)
                    for (int ch = 0; ch < N; ch++)
                        for (int t = 0; t < 3; t++) begin
                            int idx, e;
                            bit cur;
                            idx = d*6 + ch*3 + t;
                            cur = out_bit(d, ch, t);
                            if (cur && !prev[idx]) begin
                                ntests++;
                                if (exp_q[idx].size() == 0) begin
                                    nfail++;
                                    $display("FAIL %s dut%0d ch%0d: rose at edge %0d, no pulse required",
                                             tn(t), d, ch, edge_n);
                                end else begin
                                    e = exp_q[idx].pop_front();
                                    if (e != edge_n) begin
                                        nfail++;
                                        $display("FAIL %s dut%0d ch%0d: rose at edge %0d, required %0d",
                                                 tn(t), d, ch, edge_n, e);
                                    end
                                end
                                rise_at[idx] = edge_n;
                                if (first_rise[idx] < 0) first_rise[idx] = edge_n;
                            end else if (!cur && prev[idx]) begin
                                ntests++;
                                if (edge_n - rise_at[idx] != PW) begin
                                    nfail++;
                                    $display("FAIL %s_width dut%0d ch%0d: got %0d, required %0d",
                                             tn(t), d, ch, edge_n - rise_at[idx], PW);
                                end
                            end
                            prev[idx] = cur;
                        end
                for (int d = 0; d < 2; d++)
                    for (int ch = 0; ch < N; ch++) begin
                        int off;
                        off = edge_n - hbase;
                        if (off >= 0 && off < hlen) begin
                            ntests++;
                            if (ho[d][ch] != hexp[ch][off]) begin
                                nfail++;
                                $display("FAIL held dut%0d ch%0d edge %0d: got %0b, required %0b",
                                         d, ch, edge_n, ho[d][ch], hexp[ch][off]);
                            end
                        end
                    end
            end
        end
    end

    initial begin
        int b;
        repeat (3) @(negedge clk_1mhz);
        chk("reset_outs_dut0", int'({so[0], lo[0], ro[0], ho[0]}), 0);
        chk("reset_outs_dut1", int'({so[1], lo[1], ro[1], ho[1]}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_1mhz);

        clear_pat(); seg(0, 1, 10);
        run_scen(1'b0, 1'b1, b);
        chk("short_rise", first_rise[0] - b, 10 + 2 + DB + 1);
        chk("short_no_long", first_rise[1], -1);

        clear_pat();
        repeat (5) begin seg(0, 1, 3); seg(0, 0, 1); end
        run_scen(1'b0, 1'b1, b);
        chk("bounce_no_short", first_rise[0], -1);

        clear_pat(); seg(0, 1, 15); seg(0, 0, 2); seg(0, 1, 20);
        run_scen(1'b0, 1'b1, b);
        chk("glitch_long", first_rise[1] - b, 2 + DB + LP + 1 + 2);
        chk("glitch_no_short", first_rise[0], -1);

        clear_pat(); seg(1, 1, 60);
        run_scen(1'b0, 1'b1, b);
        chk("long_rise", first_rise[4] - b, 2 + DB + LP + 1);
        chk("repeat_rise", first_rise[5] - b, 2 + DB + LP + 1 + RP);
        chk("norep_long", first_rise[10] - b, 2 + DB + LP + 1);
        chk("norep_no_repeat", first_rise[11], -1);
        chk("long_no_short", first_rise[3], -1);

        clear_pat(); seg(0, 0, 5); seg(0, 1, 10); seg(1, 1, 60);
        run_scen(1'b0, 1'b1, b);
        chk("sim_short0", first_rise[0] - b, 15 + 2 + DB + 1);
        chk("sim_long1", first_rise[4] - b, 2 + DB + LP + 1);

        repeat (6) begin
            clear_pat();
            for (int ch = 0; ch < N; ch++)
                for (int s = 0; s < 6; s++) begin
                    seg(ch, 1'b1, int'($urandom_range(1, 30)));
                    seg(ch, 1'b0, int'($urandom_range(1, 7)));
                end
            run_scen(1'b0, 1'b1, b);
        end

        clear_pat(); seg(0, 0, 29); seg(1, 1, 29);
        run_scen(1'b0, 1'b0, b);
        hlen = 0;
        chk("long_before_rst", int'(lo[0][1]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs_dut0", int'({so[0], lo[0], ro[0], ho[0]}), 0);
        chk("rst_outs_dut1", int'({so[1], lo[1], ro[1], ho[1]}), 0);
        check_left();
        repeat (3) @(negedge clk_1mhz);
        clear_pat(); seg(0, 0, 40); seg(1, 1, 40);
        run_scen(1'b1, 1'b1, b);
        chk("rst_long", first_rise[4] - b, 2 + DB + LP + 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
